axi_mem_split_bank_arb: RTL
===========================

// Module: axi_mem_split_bank_arb
// PURPOSE
// - Merges the split read-port and write-port memory streams of an AXI-to-memory splitter back onto
//   NumBanks single-ported banks, so split read/write conversion works when each bank has one port.
// - Per bank: arbitrates read vs write side, tracks outstanding requests, routes each rvalid/rdata
//   back to the issuing side. Sits between the split converter and the SRAM bank array.
// PARAMETERS
// - NumBanks   4   number of banks; also the number of read ports and of write ports
// - AddrWidth  32  byte address width
// - DataWidth  32  bank data width, multiple of 8
// - RspDepth   2   max outstanding requests per bank (tracking FIFO depth, >=1)
// - MaxStall   8   write starvation limit in cycles (used only with AXI_MEM_SPLIT_ARB_STARVE_EN, >=1)
// PORTS
// - clk_i         in   1                  clock
// - rst_i         in   1                  async reset, active-high
// - rd_req_i      in   NumBanks           read-side request
// - rd_gnt_o      out  NumBanks           read-side grant
// - rd_addr_i     in   NumBanks*AddrWidth read-side byte address
// - rd_rvalid_o   out  NumBanks           read-side response valid
// - rd_rdata_o    out  NumBanks*DataWidth read-side response data
// - wr_req_i      in   NumBanks           write-side request
// - wr_gnt_o      out  NumBanks           write-side grant
// - wr_addr_i     in   NumBanks*AddrWidth write-side byte address
// - wr_wdata_i    in   NumBanks*DataWidth write data
// - wr_strb_i     in   NumBanks*DataWidth/8 byte strobe
// - wr_atop_i     in   NumBanks*6         axi_pkg::atop_t
// - wr_rvalid_o   out  NumBanks           write-side response valid (ack / atomic old data)
// - wr_rdata_o    out  NumBanks*DataWidth write-side response data
// - bank_req_o    out  NumBanks           bank request
// - bank_gnt_i    in   NumBanks           bank grant
// - bank_addr_o   out  NumBanks*AddrWidth bank address
// - bank_wdata_o  out  NumBanks*DataWidth bank write data (0 for read)
// - bank_strb_o   out  NumBanks*DataWidth/8 bank strobe (0 for read)
// - bank_atop_o   out  NumBanks*6         bank atop (0 for read)
// - bank_we_o     out  NumBanks           1 = write-side request
// - bank_rvalid_i in   NumBanks           bank response valid, one per granted request, in order
// - bank_rdata_i  in   NumBanks*DataWidth bank response data
// - busy_o        out  1                  any request pending or any response outstanding
// - err_o         out  1                  sticky: bank_rvalid_i with no outstanding request
// BEHAVIOUR
// - Reset (rst_i=1, async): all FIFOs empty, stall counters 0, err_o=0. All gnt/rvalid/bank_req low.
// - Banks fully independent. Request path combinational (0 cycles); response routing combinational.
// - Winner selection, per bank: read side wins if rd_req_i, else write side. Forward winner's
//   addr/data/strb/atop to the bank; bank_we_o=1 iff write wins.
// - bank_req_o = (rd_req_i|wr_req_i) & !fifo_full. Winner gnt = bank_gnt_i & bank_req_o. Loser gnt=0.
// - Full FIFO blocks new requests even when a pop happens in the same cycle.
// - Tracking FIFO (1 bit: side), depth RspDepth: push winner side on bank_req_o&bank_gnt_i.
//   Pop on bank_rvalid_i. Same-cycle push+pop legal; count unchanged.
// - Response: head=0 -> rd_rvalid_o=1, rd_rdata_o=bank_rdata_i. Head=1 -> wr_rvalid_o/wr_rdata_o.
//   Unselected side's rvalid=0; rdata outputs may carry bank_rdata_i unqualified.
// - bank_rvalid_i while FIFO empty: response dropped, no pop, err_o set until reset.
// - Requesters obey the mem protocol: hold req/addr/data stable until gnt. The block does not check this.
// - busy_o = |rd_req_i | |wr_req_i | any FIFO non-empty.
// - Reset mid-operation: outstanding entries discarded; later bank rvalids set err_o.
// CONFIGURATION
// - AXI_MEM_SPLIT_ARB_STARVE_EN defined: per-bank stall counter, width $clog2(MaxStall+1).
//   - Increments (saturating at MaxStall) each cycle wr_req_i=1 and write not granted.
//   - Clears to 0 on write grant or when wr_req_i=0.
//   - At MaxStall, write side wins over read until its next grant.
// - Not defined: no counter; strict read priority; write may starve indefinitely.
// TESTING
// - Read bank0 addr 0x10, bank rvalid 1 cycle later, rdata 0xCAFE -> rd_gnt_o[0]=1 same cycle,
//   bank_we_o=0, rd_rvalid_o[0]=1 with 0xCAFE, wr_rvalid_o[0]=0.
// - Read+write both request bank1 -> read granted first, write granted next cycle;
//   responses routed rd then wr in issue order.
// - RspDepth=2, bank never returns rvalid, 3 reads -> 2 grants, 3rd held with bank_req_o=0
//   until one rvalid pops the FIFO.
// - bank_rvalid_i[2] with empty FIFO -> both side rvalids 0, err_o=1 and stays 1 until rst_i.
// - STARVE_EN, MaxStall=8, read req held high, write req held high -> write granted exactly
//   after 8 stall cycles; without macro the write is never granted.
// - rst_i asserted with 2 outstanding -> outputs low at once, busy_o=0 after inputs drop.

Source files
------------

// File: rtl/axi_mem_split_bank_arb.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_split_bank_arb
// Purpose  : Merges split read-port and write-port memory streams onto
//            NumBanks single-ported banks. Per bank, it picks the read or the
//            write side, records which side issued each granted request, and
//            routes every bank response back to the side that issued it.
// Ports    : clk_i/rst_i            clock, async active-high reset
//            rd_*                   read-side mem ports (req/gnt/addr/rvalid/rdata)
//            wr_*                   write-side mem ports (+wdata/strb/atop)
//            bank_*                 bank-side mem ports, one lane per bank
//            busy_o                 any request pending or response outstanding
//            err_o                  sticky: bank response with nothing outstanding
// Config   : AXI_MEM_SPLIT_ARB_STARVE_EN enables per-bank write starvation
//            protection (write wins after MaxStall cycles of waiting).
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_split_bank_arb #(
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RspDepth  = 2,
  parameter int unsigned MaxStall  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumBanks-1:0]             rd_req_i,
  output logic [NumBanks-1:0]             rd_gnt_o,
  input  logic [NumBanks*AddrWidth-1:0]   rd_addr_i,
  output logic [NumBanks-1:0]             rd_rvalid_o,
  output logic [NumBanks*DataWidth-1:0]   rd_rdata_o,
  input  logic [NumBanks-1:0]             wr_req_i,
  output logic [NumBanks-1:0]             wr_gnt_o,
  input  logic [NumBanks*AddrWidth-1:0]   wr_addr_i,
  input  logic [NumBanks*DataWidth-1:0]   wr_wdata_i,
  input  logic [NumBanks*DataWidth/8-1:0] wr_strb_i,
  input  logic [NumBanks*6-1:0]           wr_atop_i,
  output logic [NumBanks-1:0]             wr_rvalid_o,
  output logic [NumBanks*DataWidth-1:0]   wr_rdata_o,
  output logic [NumBanks-1:0]             bank_req_o,
  input  logic [NumBanks-1:0]             bank_gnt_i,
  output logic [NumBanks*AddrWidth-1:0]   bank_addr_o,
  output logic [NumBanks*DataWidth-1:0]   bank_wdata_o,
  output logic [NumBanks*DataWidth/8-1:0] bank_strb_o,
  output logic [NumBanks*6-1:0]           bank_atop_o,
  output logic [NumBanks-1:0]             bank_we_o,
  input  logic [NumBanks-1:0]             bank_rvalid_i,
  input  logic [NumBanks*DataWidth-1:0]   bank_rdata_i,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(RspDepth + 1);

  if (RspDepth < 1 || MaxStall < 1 || (DataWidth % 8) != 0) begin : g_param_check
    $error("axi_mem_split_bank_arb: illegal parameter combination");
  end

  logic [NumBanks-1:0] busy_bank;
  logic [NumBanks-1:0] drop_bank;
  logic                err_q;

  // Response data is not qualified; the per-side rvalid tells the owner.
  assign rd_rdata_o = bank_rdata_i;
  assign wr_rdata_o = bank_rdata_i;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [RspDepth-1:0] side_q, side_d;   // bit 0 is the oldest entry; 1 = write side
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] wr_idx;
    logic                wr_pri;
    logic                wr_wins;
    logic                full;
    logic                req;
    logic                push;
    logic                pop;
    logic                has_entry;

`ifdef AXI_MEM_SPLIT_ARB_STARVE_EN
    localparam int unsigned StallWidth = $clog2(MaxStall + 1);
    logic [StallWidth-1:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if (!wr_req_i[b] || wr_gnt_o[b]) begin
        stall_d = '0;
      end else if (stall_q != StallWidth'(MaxStall)) begin
        stall_d = stall_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_q <= '0;
      else       stall_q <= stall_d;
    end

    // Saturated counter keeps write priority until the write is granted.
    assign wr_pri = (stall_q == StallWidth'(MaxStall));
`else
    assign wr_pri = 1'b0;
`endif

    assign wr_wins   = wr_req_i[b] & (~rd_req_i[b] | wr_pri);
    assign full      = (cnt_q == CntWidth'(RspDepth));
    assign has_entry = (cnt_q != '0);
    // Fullness uses the registered count, so a same-cycle pop does not free a slot.
    assign req       = (rd_req_i[b] | wr_req_i[b]) & ~full & ~rst_i;
    assign push      = req & bank_gnt_i[b];
    assign pop       = bank_rvalid_i[b] & has_entry;

    assign bank_req_o[b] = req;
    assign bank_we_o[b]  = wr_wins;
    assign rd_gnt_o[b]   = push & ~wr_wins;
    assign wr_gnt_o[b]   = push & wr_wins;

    assign bank_addr_o[b*AddrWidth +: AddrWidth]  = wr_wins ? wr_addr_i[b*AddrWidth +: AddrWidth]
                                                             : rd_addr_i[b*AddrWidth +: AddrWidth];
    assign bank_wdata_o[b*DataWidth +: DataWidth] = wr_wins ? wr_wdata_i[b*DataWidth +: DataWidth] : '0;
    assign bank_strb_o[b*StrbWidth +: StrbWidth]  = wr_wins ? wr_strb_i[b*StrbWidth +: StrbWidth] : '0;
    assign bank_atop_o[b*6 +: 6]                  = wr_wins ? wr_atop_i[b*6 +: 6] : '0;

    assign rd_rvalid_o[b] = pop & ~side_q[0];
    assign wr_rvalid_o[b] = pop & side_q[0];
    assign drop_bank[b]   = bank_rvalid_i[b] & ~has_entry;
    assign busy_bank[b]   = rd_req_i[b] | wr_req_i[b] | has_entry;

    // Shift-register FIFO: pop shifts toward bit 0, push lands after the last live entry.
    always_comb begin
      side_d = side_q;
      cnt_d  = cnt_q;
      wr_idx = cnt_q;
      if (pop) begin
        side_d = side_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        wr_idx = cnt_q - 1'b1;
      end
      if (push) begin
        for (int i = 0; i < RspDepth; i++) begin
          if (CntWidth'(i) == wr_idx) side_d[i] = wr_wins;
        end
        cnt_d = cnt_d + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        side_q <= '0;
        cnt_q  <= '0;
      end else begin
        side_q <= side_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | (|drop_bank);
  end

  assign err_o  = err_q;
  assign busy_o = |busy_bank;

endmodule
`default_nettype wire
